// File: rtl/cv32e40p_alu_permanent_fault_detector.sv
// Per-ALU permanent-fault detector: leaky mismatch counters fed by TMR voter outcomes,
// with sticky fault flags and registered event pulses for the faulty-ALU decoder.

module cv32e40p_alu_pfd_lane #(
    parameter int CNT_W     = 4,
    parameter int THRESHOLD = 8,
    parameter int DECAY_LEN = 16,
    parameter int STRK_W    = $clog2(DECAY_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_en,
    input  logic             mismatch,
    output logic             flag,
    output logic [CNT_W-1:0] cnt,
    output logic             rise
);
    localparam logic [CNT_W-1:0]  THR     = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [STRK_W-1:0] STRK_LAST = STRK_W'(DECAY_LEN - 1);

    logic [STRK_W-1:0] streak, streak_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              flag_d;

    always_comb begin
        cnt_d    = cnt;
        streak_d = streak;
        flag_d   = flag;
        rise     = 1'b0;
        if (clear) begin
            cnt_d    = '0;
            streak_d = '0;
            flag_d   = 1'b0;
        end else if (count_en) begin
            if (mismatch) begin
                // A mismatch always beats a streak that would complete this cycle.
                streak_d = '0;
                if (cnt != CNT_MAX)
                    cnt_d = cnt + 1'b1;
                if (cnt_d == THR) begin
                    flag_d = 1'b1;
                    rise   = 1'b1;
                end
            end else if (streak == STRK_LAST) begin
                streak_d = '0;
                if (cnt != '0)
                    cnt_d = cnt - 1'b1;
            end else begin
                streak_d = streak + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            streak <= '0;
            flag   <= 1'b0;
        end else begin
            cnt    <= cnt_d;
            streak <= streak_d;
            flag   <= flag_d;
        end
    end
endmodule

module cv32e40p_alu_permanent_fault_detector #(
    parameter int N_ALU     = 4,
    parameter int CNT_W     = 4,
    parameter int THRESHOLD = 8,
    parameter int DECAY_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vote_valid_i,
    input  logic [N_ALU-1:0]       active_alu_i,
    input  logic [N_ALU-1:0]       mismatch_i,
    input  logic                   clear_i,
    output logic [N_ALU-1:0]       permanent_faulty_alu_o,
    output logic                   new_fault_o,
    output logic                   no_majority_o,
    output logic [N_ALU*CNT_W-1:0] fault_cnt_o
);
    logic [N_ALU-1:0]            flags, eff_mm, count_en, rise;
    logic [N_ALU-1:0][CNT_W-1:0] cnt;
    logic                        ambiguous;

    // Faulty replicas no longer vote here, so they cannot make a vote ambiguous.
    assign eff_mm    = {N_ALU{vote_valid_i}} & mismatch_i & active_alu_i & ~flags;
    assign ambiguous = (eff_mm & (eff_mm - 1'b1)) != '0;
    assign count_en  = {N_ALU{vote_valid_i & ~ambiguous}} & active_alu_i & ~flags;

    for (genvar i = 0; i < N_ALU; i++) begin : g_lane
        cv32e40p_alu_pfd_lane #(
            .CNT_W    (CNT_W),
            .THRESHOLD(THRESHOLD),
            .DECAY_LEN(DECAY_LEN)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear_i),
            .count_en(count_en[i]),
            .mismatch(mismatch_i[i]),
            .flag    (flags[i]),
            .cnt     (cnt[i]),
            .rise    (rise[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            new_fault_o   <= 1'b0;
            no_majority_o <= 1'b0;
        end else begin
            new_fault_o   <= ~clear_i & (|rise);
            no_majority_o <= ~clear_i & ambiguous;
        end
    end

    assign permanent_faulty_alu_o = flags;
    assign fault_cnt_o            = cnt;
endmodule

// File: tb/tb_cv32e40p_alu_permanent_fault_detector.sv
// Bench for the ALU permanent-fault detector: directed table, hand sequences, and
// randomized traffic checked against an abstract per-ALU model.

module tb_cv32e40p_alu_permanent_fault_detector;
    localparam int N = 4;
    localparam int THR = 8;
    localparam int DLEN = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        vote_valid_i;
    logic [3:0]  active_alu_i;
    logic [3:0]  mismatch_i;
    logic        clear_i;
    logic [3:0]  permanent_faulty_alu_o;
    logic        new_fault_o;
    logic        no_majority_o;
    logic [15:0] fault_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    int mcnt[N];
    int mstreak[N];
    bit mflag[N];
    bit mnf, mnm;

    cv32e40p_alu_permanent_fault_detector dut (
        .clk                   (clk),
        .rst                   (rst),
        .vote_valid_i          (vote_valid_i),
        .active_alu_i          (active_alu_i),
        .mismatch_i            (mismatch_i),
        .clear_i               (clear_i),
        .permanent_faulty_alu_o(permanent_faulty_alu_o),
        .new_fault_o           (new_fault_o),
        .no_majority_o         (no_majority_o),
        .fault_cnt_o           (fault_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: per-ALU counters driven straight from the behavioural rules.
    task automatic model_step(input bit r, input bit vv, input logic [3:0] act,
                              input logic [3:0] mm, input bit clr);
        int n;
        if (r || clr) begin
            for (int i = 0; i < N; i++) begin
                mcnt[i] = 0; mstreak[i] = 0; mflag[i] = 0;
            end
            mnf = 0; mnm = 0;
            return;
        end
        n = 0;
        for (int i = 0; i < N; i++)
            if (vv && act[i] && mm[i] && !mflag[i]) n++;
        mnm = (n > 1);
        mnf = 0;
        if (!vv || n > 1) return;
        for (int i = 0; i < N; i++) begin
            if (!act[i] || mflag[i]) continue;
            if (mm[i]) begin
                if (mcnt[i] < 15) mcnt[i]++;
                mstreak[i] = 0;
                if (mcnt[i] == THR) begin
                    mflag[i] = 1; mnf = 1;
                end
            end else begin
                mstreak[i]++;
                if (mstreak[i] == DLEN) begin
                    mstreak[i] = 0;
                    if (mcnt[i] > 0) mcnt[i]--;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [3:0]  ef;
        logic [15:0] ec;
        for (int i = 0; i < N; i++) begin
            ef[i] = mflag[i];
            ec[i*4 +: 4] = mcnt[i][3:0];
        end
        chk("model_flags", 32'(permanent_faulty_alu_o), 32'(ef));
        chk("model_cnt", 32'(fault_cnt_o), 32'(ec));
        chk("model_new_fault", 32'(new_fault_o), 32'(mnf));
        chk("model_no_majority", 32'(no_majority_o), 32'(mnm));
    endtask

    task automatic cycle(input bit r, input bit vv, input logic [3:0] act,
                         input logic [3:0] mm, input bit clr);
        rst = r; vote_valid_i = vv; active_alu_i = act; mismatch_i = mm; clear_i = clr;
        model_step(r, vv, act, mm, clr);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic vote(input logic [3:0] act, input logic [3:0] mm, input int times);
        for (int k = 0; k < times; k++) cycle(0, 1, act, mm, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 4'h0, 4'h0, 0);
    endtask

    typedef struct {
        logic        vv;
        logic [3:0]  act;
        logic [3:0]  mm;
        logic [3:0]  exp_flags;
        logic        exp_nf;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        for (int k = 1; k <= 8; k++)
            tbl[k-1] = '{1'b1, 4'b0111, 4'b0010, (k == 8) ? 4'b0010 : 4'b0000,
                         (k == 8) ? 1'b1 : 1'b0, 16'(k << 4)};
        tbl[8] = '{1'b1, 4'b1101, 4'b0010, 4'b0010, 1'b0, 16'h0080};

        rst = 1; vote_valid_i = 0; active_alu_i = 0; mismatch_i = 0; clear_i = 0;

        // Reset with random inputs
        for (int k = 0; k < 2; k++)
            cycle(1, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        chk("reset_flags", 32'(permanent_faulty_alu_o), 0);
        chk("reset_cnt", 32'(fault_cnt_o), 0);
        chk("reset_nf", 32'(new_fault_o), 0);
        chk("reset_nm", 32'(no_majority_o), 0);

        // Threshold table
        for (int k = 0; k < 9; k++) begin
            cycle(0, tbl[k].vv, tbl[k].act, tbl[k].mm, 0);
            chk($sformatf("thr_flags[%0d]", k), 32'(permanent_faulty_alu_o), 32'(tbl[k].exp_flags));
            chk($sformatf("thr_nf[%0d]", k), 32'(new_fault_o), 32'(tbl[k].exp_nf));
            chk($sformatf("thr_cnt[%0d]", k), 32'(fault_cnt_o), 32'(tbl[k].exp_cnt));
        end

        // Decay
        do_reset();
        vote(4'b0001, 4'b0001, 3);
        vote(4'b0001, 4'b0000, 15);
        chk("decay_cnt_15clean", 32'(fault_cnt_o), 32'h3);
        vote(4'b0001, 4'b0000, 1);
        chk("decay_cnt_16clean", 32'(fault_cnt_o), 32'h2);
        vote(4'b0001, 4'b0000, 32);
        chk("decay_cnt_48clean", 32'(fault_cnt_o), 32'h0);
        vote(4'b0001, 4'b0001, 3);
        vote(4'b0001, 4'b0000, 15);
        vote(4'b0001, 4'b0001, 1);
        chk("decay_mm_on_16th", 32'(fault_cnt_o), 32'h4);
        vote(4'b0001, 4'b0000, 15);
        chk("decay_restart_15", 32'(fault_cnt_o), 32'h4);
        vote(4'b0001, 4'b0000, 1);
        chk("decay_restart_16", 32'(fault_cnt_o), 32'h3);

        // Ambiguity
        do_reset();
        vote(4'b0100, 4'b0100, 1);
        vote(4'b0111, 4'b0011, 1);
        chk("amb_nm", 32'(no_majority_o), 1);
        chk("amb_cnt", 32'(fault_cnt_o), 32'h0100);
        cycle(0, 0, 4'hf, 4'hf, 0);
        chk("amb_nm_pulse_end", 32'(no_majority_o), 0);

        // Clear priority
        do_reset();
        vote(4'b0100, 4'b0100, 7);
        chk("clr_pre_cnt", 32'(fault_cnt_o), 32'h0700);
        cycle(0, 1, 4'b0100, 4'b0100, 1);
        chk("clr_flags", 32'(permanent_faulty_alu_o), 0);
        chk("clr_cnt", 32'(fault_cnt_o), 0);
        chk("clr_nf", 32'(new_fault_o), 0);

        // Reset mid-operation
        do_reset();
        vote(4'b0001, 4'b0001, 8);
        vote(4'b0010, 4'b0010, 5);
        chk("mid_pre_flags", 32'(permanent_faulty_alu_o), 32'b0001);
        chk("mid_pre_cnt", 32'(fault_cnt_o), 32'h0058);
        do_reset();
        chk("mid_rst_flags", 32'(permanent_faulty_alu_o), 0);
        chk("mid_rst_cnt", 32'(fault_cnt_o), 0);
        vote(4'b0010, 4'b0010, 7);
        chk("mid_7_flags", 32'(permanent_faulty_alu_o), 0);
        chk("mid_7_cnt", 32'(fault_cnt_o), 32'h0070);
        vote(4'b0010, 4'b0010, 1);
        chk("mid_8_flags", 32'(permanent_faulty_alu_o), 32'b0010);
        chk("mid_8_nf", 32'(new_fault_o), 1);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            logic [3:0] mm;
            for (int b = 0; b < 4; b++) mm[b] = ($urandom_range(0, 5) == 0);
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
                  4'($urandom), mm, $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
